// File: rtl/pipe_stage_reg.sv
// Pipeline slot register: holds one instruction between two stages and
// handles hold, bubble insertion and flush, with stall/bubble statistics.
module pipe_stage_reg #(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned TNEW_W     = 3,
    parameter int unsigned TNEW_DEC   = 1,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter bit          CLEAR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              hold,
    input  logic              bubble,
    input  logic              in_valid,
    input  logic [31:0]       in_pc,
    input  logic              in_regwrite,
    input  logic              in_memwrite,
    input  logic [4:0]        in_a3,
    input  logic [TNEW_W-1:0] in_tnew,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [31:0]       out_pc,
    output logic              out_regwrite,
    output logic              out_memwrite,
    output logic [4:0]        out_a3,
    output logic [TNEW_W-1:0] out_tnew,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       bubble_cnt,
    output logic [15:0]       hold_cnt
);

    localparam logic [TNEW_W:0] DEC = (TNEW_W+1)'(TNEW_DEC);

    logic [TNEW_W:0]   tnew_ext;
    logic [TNEW_W:0]   tnew_diff;
    logic [TNEW_W-1:0] tnew_next;
    logic              empty;

    assign tnew_ext  = {1'b0, in_tnew};
    assign tnew_diff = tnew_ext - DEC;
    // Result-ready countdown floors at zero rather than wrapping.
    assign tnew_next = (tnew_ext > DEC) ? tnew_diff[TNEW_W-1:0]
                                        : '0;

    assign empty = flush || (!hold && bubble);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_pc       <= RESET_PC;
            out_regwrite <= 1'b0;
            out_memwrite <= 1'b0;
            out_a3       <= '0;
            out_tnew     <= '0;
            out_data     <= '0;
            bubble_cnt   <= '0;
            hold_cnt     <= '0;
        end else if (empty) begin
            out_valid    <= 1'b0;
            out_pc       <= RESET_PC;
            out_regwrite <= 1'b0;
            out_memwrite <= 1'b0;
            out_a3       <= '0;
            out_tnew     <= '0;
            if (CLEAR_DATA)
                out_data <= '0;
            if (bubble_cnt != 16'hFFFF)
                bubble_cnt <= bubble_cnt + 16'd1;
        end else if (hold) begin
            if (hold_cnt != 16'hFFFF)
                hold_cnt <= hold_cnt + 16'd1;
        end else begin
            out_valid    <= in_valid;
            out_pc       <= in_pc;
            out_regwrite <= in_valid && in_regwrite;
            out_memwrite <= in_valid && in_memwrite;
            out_a3       <= in_a3;
            out_tnew     <= tnew_next;
            out_data     <= in_data;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed checks for pipe_stage_reg: three instances sharing stimulus
// (default, payload-clearing, and no Tnew decrement).
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         reset, flush, hold, bubble;
    logic         in_valid, in_regwrite, in_memwrite;
    logic [31:0]  in_pc;
    logic [4:0]   in_a3;
    logic [2:0]   in_tnew;
    logic [127:0] in_data;

    logic         a_valid, a_rw, a_mw;
    logic [31:0]  a_pc;
    logic [4:0]   a_a3;
    logic [2:0]   a_tnew;
    logic [127:0] a_data;
    logic [15:0]  a_bcnt, a_hcnt;

    logic         b_valid, b_rw, b_mw;
    logic [31:0]  b_pc;
    logic [4:0]   b_a3;
    logic [2:0]   b_tnew;
    logic [127:0] b_data;
    logic [15:0]  b_bcnt, b_hcnt;

    logic         c_valid, c_rw, c_mw;
    logic [31:0]  c_pc;
    logic [4:0]   c_a3;
    logic [2:0]   c_tnew;
    logic [127:0] c_data;
    logic [15:0]  c_bcnt, c_hcnt;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_reg u_a (
        .clk(clk), .reset(reset), .flush(flush), .hold(hold),
        .bubble(bubble), .in_valid(in_valid), .in_pc(in_pc),
        .in_regwrite(in_regwrite), .in_memwrite(in_memwrite),
        .in_a3(in_a3), .in_tnew(in_tnew), .in_data(in_data),
        .out_valid(a_valid), .out_pc(a_pc), .out_regwrite(a_rw),
        .out_memwrite(a_mw), .out_a3(a_a3), .out_tnew(a_tnew),
        .out_data(a_data), .bubble_cnt(a_bcnt), .hold_cnt(a_hcnt)
    );

    pipe_stage_reg #(.CLEAR_DATA(1'b1)) u_b (
        .clk(clk), .reset(reset), .flush(flush), .hold(hold),
        .bubble(bubble), .in_valid(in_valid), .in_pc(in_pc),
        .in_regwrite(in_regwrite), .in_memwrite(in_memwrite),
        .in_a3(in_a3), .in_tnew(in_tnew), .in_data(in_data),
        .out_valid(b_valid), .out_pc(b_pc), .out_regwrite(b_rw),
        .out_memwrite(b_mw), .out_a3(b_a3), .out_tnew(b_tnew),
        .out_data(b_data), .bubble_cnt(b_bcnt), .hold_cnt(b_hcnt)
    );

    pipe_stage_reg #(.TNEW_DEC(0)) u_c (
        .clk(clk), .reset(reset), .flush(flush), .hold(hold),
        .bubble(bubble), .in_valid(in_valid), .in_pc(in_pc),
        .in_regwrite(in_regwrite), .in_memwrite(in_memwrite),
        .in_a3(in_a3), .in_tnew(in_tnew), .in_data(in_data),
        .out_valid(c_valid), .out_pc(c_pc), .out_regwrite(c_rw),
        .out_memwrite(c_mw), .out_a3(c_a3), .out_tnew(c_tnew),
        .out_data(c_data), .bubble_cnt(c_bcnt), .hold_cnt(c_hcnt)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic v, input logic [31:0] pc,
                        input logic rw, input logic mw,
                        input logic [4:0] a3, input logic [2:0] tn,
                        input logic [127:0] d);
        in_valid = v; in_pc = pc; in_regwrite = rw;
        in_memwrite = mw; in_a3 = a3; in_tnew = tn; in_data = d;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".valid"}, a_valid, 1'b0);
        chk({tag, ".pc"}, a_pc, 32'h3000);
        chk({tag, ".rw"}, a_rw, 1'b0);
        chk({tag, ".mw"}, a_mw, 1'b0);
        chk({tag, ".a3"}, a_a3, 5'd0);
        chk({tag, ".tnew"}, a_tnew, 3'd0);
        chk({tag, ".data"}, a_data, 128'd0);
        chk({tag, ".bcnt"}, a_bcnt, 16'd0);
        chk({tag, ".hcnt"}, a_hcnt, 16'd0);
    endtask

    localparam logic [127:0] D1 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] D2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] D3 = 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0;

    initial begin
        reset = 1'b1; flush = 1'b0; hold = 1'b0; bubble = 1'b0;
        load(1'b1, 32'h1234, 1'b1, 1'b1, 5'd31, 3'd7, D3);
        step();
        chk_reset("rst");
        chk("rst.b_data", b_data, 128'd0);

        // plain load
        reset = 1'b0;
        load(1'b1, 32'h3004, 1'b1, 1'b0, 5'd8, 3'd2, D1);
        step();
        chk("ld.pc", a_pc, 32'h3004);
        chk("ld.a3", a_a3, 5'd8);
        chk("ld.rw", a_rw, 1'b1);
        chk("ld.mw", a_mw, 1'b0);
        chk("ld.valid", a_valid, 1'b1);
        chk("ld.tnew", a_tnew, 3'd1);
        chk("ld.data", a_data, D1);
        chk("ld.c_tnew", c_tnew, 3'd2);

        // tnew floor
        load(1'b1, 32'h3008, 1'b0, 1'b1, 5'd3, 3'd0, D2);
        step();
        chk("floor.tnew", a_tnew, 3'd0);
        chk("floor.pc", a_pc, 32'h3008);
        chk("floor.mw", a_mw, 1'b1);

        // bubble
        bubble = 1'b1;
        step();
        bubble = 1'b0;
        chk("bub.pc", a_pc, 32'h3000);
        chk("bub.valid", a_valid, 1'b0);
        chk("bub.rw", a_rw, 1'b0);
        chk("bub.mw", a_mw, 1'b0);
        chk("bub.a3", a_a3, 5'd0);
        chk("bub.bcnt", a_bcnt, 16'd1);
        chk("bub.a_data", a_data, D2);
        chk("bub.b_data", b_data, 128'd0);
        chk("bub.hcnt", a_hcnt, 16'd0);

        // hold three edges, then flush wins over hold
        reset = 1'b1;
        step();
        reset = 1'b0;
        load(1'b1, 32'h300C, 1'b1, 1'b0, 5'd9, 3'd3, D3);
        step();
        hold = 1'b1;
        load(1'b1, 32'h4444, 1'b0, 1'b1, 5'd1, 3'd1, D1);
        repeat (3) step();
        chk("hold.pc", a_pc, 32'h300C);
        chk("hold.a3", a_a3, 5'd9);
        chk("hold.tnew", a_tnew, 3'd2);
        chk("hold.data", a_data, D3);
        chk("hold.rw", a_rw, 1'b1);
        chk("hold.hcnt", a_hcnt, 16'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl.valid", a_valid, 1'b0);
        chk("fl.pc", a_pc, 32'h3000);
        chk("fl.rw", a_rw, 1'b0);
        chk("fl.hcnt", a_hcnt, 16'd3);
        chk("fl.bcnt", a_bcnt, 16'd1);
        chk("fl.a_data", a_data, D3);
        chk("fl.b_data", b_data, 128'd0);

        // hold beats bubble
        hold = 1'b0;
        load(1'b1, 32'h3010, 1'b0, 1'b1, 5'd4, 3'd5, D2);
        step();
        hold = 1'b1; bubble = 1'b1;
        step();
        hold = 1'b0; bubble = 1'b0;
        chk("hb.pc", a_pc, 32'h3010);
        chk("hb.valid", a_valid, 1'b1);
        chk("hb.tnew", a_tnew, 3'd4);
        chk("hb.bcnt", a_bcnt, 16'd1);
        chk("hb.hcnt", a_hcnt, 16'd4);

        // invalid load masks write enables
        load(1'b0, 32'h3014, 1'b1, 1'b1, 5'd7, 3'd3, D1);
        step();
        chk("inv.rw", a_rw, 1'b0);
        chk("inv.mw", a_mw, 1'b0);
        chk("inv.pc", a_pc, 32'h3014);
        chk("inv.a3", a_a3, 5'd7);
        chk("inv.valid", a_valid, 1'b0);
        chk("inv.tnew", a_tnew, 3'd2);

        // bubble counter saturation
        reset = 1'b1;
        step();
        reset = 1'b0;
        bubble = 1'b1;
        repeat (65534) step();
        chk("sat.fffe", a_bcnt, 16'hFFFE);
        step();
        chk("sat.ffff", a_bcnt, 16'hFFFF);
        step();
        chk("sat.stay", a_bcnt, 16'hFFFF);
        chk("sat.b_stay", b_bcnt, 16'hFFFF);
        chk("sat.hcnt", a_hcnt, 16'd0);

        // reset in the middle of a hold
        bubble = 1'b0;
        load(1'b1, 32'h3020, 1'b1, 1'b1, 5'd12, 3'd6, D1);
        step();
        hold = 1'b1;
        repeat (2) step();
        chk("rh.hcnt", a_hcnt, 16'd2);
        reset = 1'b1;
        step();
        chk_reset("rh");
        reset = 1'b0;
        step();
        chk("rh.after_hcnt", a_hcnt, 16'd1);
        chk("rh.after_pc", a_pc, 32'h3000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL provide parameter DATA_W, default 128, width of opaque payload bus.
REQ-002 SHALL provide parameter TNEW_W, default 3, width of Tnew field.
REQ-003 SHALL provide parameter TNEW_DEC, default 1, amount subtracted from Tnew on load (0 disables).
REQ-004 SHALL provide parameter RESET_PC, default 32'h0000_3000, PC value of an empty slot.
REQ-005 SHALL provide parameter CLEAR_DATA, default 0, 1 = payload zeroed on bubble/flush, 0 = payload retained.
REQ-006 clk  in  1  clock, all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 flush  in  1  kill slot contents (exception/redirect).
REQ-009 hold  in  1  freeze slot (downstream stall).
REQ-010 bubble  in  1  load empty slot instead of upstream (upstream hazard stall).
REQ-011 in_valid  in  1  upstream slot holds a real instruction.
REQ-012 in_pc  in  32  upstream PC.
REQ-013 in_regwrite  in  1  upstream register-write enable.
REQ-014 in_memwrite  in  1  upstream memory-write enable.
REQ-015 in_a3  in  5  upstream destination register.
REQ-016 in_tnew  in  TNEW_W  upstream cycles-until-result.
REQ-017 in_data  in  DATA_W  upstream payload (operands, imm, op codes).
REQ-018 out_valid, out_pc, out_regwrite, out_memwrite, out_a3, out_tnew, out_data  out  widths as inputs  registered slot contents.
REQ-019 bubble_cnt  out  16  saturating count of empty-slot insertions.
REQ-020 hold_cnt  out  16  saturating count of hold cycles.

Function
REQ-021 SHALL evaluate controls per edge with priority reset > flush > hold > bubble > load.
REQ-022 Load (no control asserted) SHALL copy all in_* to out_* with one-cycle latency.
REQ-023 On load, out_tnew SHALL equal in_tnew - TNEW_DEC, saturating at 0 (in_tnew=0 -> 0).
REQ-024 On load with in_valid=0, out_regwrite and out_memwrite SHALL be 0 regardless of inputs; other fields copied.
REQ-025 Hold SHALL keep every out_* unchanged; hold_cnt increments by 1 (saturates at 16'hFFFF).
REQ-026 Bubble or flush SHALL set out_valid=0, out_regwrite=0, out_memwrite=0, out_tnew=0, out_a3=0, out_pc=RESET_PC.
REQ-027 Bubble or flush SHALL zero out_data when CLEAR_DATA=1, else leave out_data unchanged.
REQ-028 Bubble or flush SHALL increment bubble_cnt by 1 (saturates at 16'hFFFF); counters never wrap.
REQ-029 Flush with hold asserted SHALL still empty the slot (flush wins); hold_cnt not incremented that cycle.
REQ-030 Hold with bubble asserted SHALL hold; bubble ignored, bubble_cnt not incremented.
REQ-031 Outputs SHALL be driven only from registers; no combinational path from in_* or controls to out_*.

Reset
REQ-032 On reset, out_valid=0, out_regwrite=0, out_memwrite=0, out_tnew=0, out_a3=0, out_pc=RESET_PC, out_data=0, bubble_cnt=0, hold_cnt=0.
REQ-033 Reset asserted mid-hold or mid-bubble SHALL override all controls that edge; normal priority resumes the edge after deassertion.

Verification
REQ-034 Load: in_valid=1, in_pc=32'h3004, in_a3=5'd8, in_regwrite=1, in_tnew=3'd2 -> next cycle out_pc=32'h3004, out_a3=8, out_regwrite=1, out_tnew=1.
REQ-035 Tnew floor: in_tnew=0, load -> out_tnew=0; TNEW_DEC=0 instance, in_tnew=2 -> out_tnew=2.
REQ-036 Bubble: slot holds pc 32'h3008, bubble=1 for one edge -> out_pc=32'h3000, out_regwrite=0, out_valid=0, bubble_cnt=1; out_data retained with CLEAR_DATA=0, zero with CLEAR_DATA=1.
REQ-037 Hold vs. flush: slot loaded, hold=1 three edges -> outputs unchanged, hold_cnt=3; then hold=1, flush=1 -> slot emptied, hold_cnt=3, bubble_cnt=1.
REQ-038 Invalid load: in_valid=0, in_regwrite=1, in_memwrite=1 -> out_regwrite=0, out_memwrite=0, out_pc=in_pc.
REQ-039 Saturation/reset: force 65536 bubbles -> bubble_cnt=16'hFFFF and stays; reset during hold -> all REQ-032 values next edge.
